// File: rtl/fft_modulus_calc.sv
// Turns FFT bins into re^2+im^2 power words tagged {sop, eop, bin_idx} for the modulus FIFO.
// Capture starts and stops on frame boundaries. The 3-stage pipeline stalls as a whole on FIFO backpressure.
module fft_modulus_calc #(
  parameter int IN_WIDTH  = 29,
  parameter int IDX_WIDTH = 13,
  parameter int PWR_WIDTH = 2*IN_WIDTH,
  parameter int OUT_WIDTH = 2 + IDX_WIDTH + PWR_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_re,
  input  logic [IN_WIDTH-1:0]  in_im,
  input  logic                 in_last,
  output logic                 fifo_wr_en,
  input  logic                 fifo_wr_vld,
  output logic [OUT_WIDTH-1:0] fifo_wr_data,
  output logic                 running,
  output logic [15:0]          frame_cnt,
  output logic                 frame_err
);
  typedef enum logic {IDLE, RUN} state_e;
  localparam logic [IDX_WIDTH-1:0] IDX_MAX = '1;

  state_e                          state_q, state_d;
  logic [IDX_WIDTH-1:0]            cnt_q, cnt_d;
  logic [3:1]                      vld_pipe_q, vld_pipe_d;
  logic [3:1]                      sop_q, sop_d, eop_q, eop_d;
  logic [3:1][IDX_WIDTH-1:0]       idx_q, idx_d;
  logic signed [IN_WIDTH-1:0]      s1_re_q, s1_re_d, s1_im_q, s1_im_d;
  logic [PWR_WIDTH-1:0]            s2_rr_q, s2_rr_d, s2_ii_q, s2_ii_d;
  logic [PWR_WIDTH-1:0]            s3_pwr_q, s3_pwr_d;
  logic [15:0]                     frame_cnt_q, frame_cnt_d;
  logic                            frame_err_q, frame_err_d;
  logic                            advance, accept, run_acc, wrap;
  logic signed [PWR_WIDTH-1:0]     re_x, im_x;

  always_comb begin
    advance  = !vld_pipe_q[3] || fifo_wr_vld;
    in_ready = (state_q == IDLE) || advance;
    accept   = in_valid && in_ready;
    run_acc  = accept && (state_q == RUN);
    wrap     = (cnt_q == IDX_MAX);
    re_x     = {{(PWR_WIDTH-IN_WIDTH){s1_re_q[IN_WIDTH-1]}}, s1_re_q};
    im_x     = {{(PWR_WIDTH-IN_WIDTH){s1_im_q[IN_WIDTH-1]}}, s1_im_q};

    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    vld_pipe_d  = vld_pipe_q;
    sop_d       = sop_q;
    eop_d       = eop_q;
    idx_d       = idx_q;
    s1_re_d     = s1_re_q;
    s1_im_d     = s1_im_q;
    s2_rr_d     = s2_rr_q;
    s2_ii_d     = s2_ii_q;
    s3_pwr_d    = s3_pwr_q;

    // en only matters on the beat that closes a frame
    if (accept && in_last) begin
      if (state_q == IDLE && en)       state_d = RUN;
      else if (state_q == RUN && !en)  state_d = IDLE;
    end

    // A frame is wrong whenever in_last and a full count disagree; either one closes it
    if (run_acc) begin
      cnt_d = (in_last || wrap) ? '0 : cnt_q + 1'b1;
      if (in_last != wrap) frame_err_d = 1'b1;
    end

    if (advance) begin
      vld_pipe_d = {vld_pipe_q[2:1], run_acc};
      if (run_acc) begin
        s1_re_d  = in_re;
        s1_im_d  = in_im;
        idx_d[1] = cnt_q;
        sop_d[1] = (cnt_q == '0);
        eop_d[1] = in_last || wrap;
      end
      s2_rr_d  = re_x * re_x;
      s2_ii_d  = im_x * im_x;
      idx_d[2] = idx_q[1];
      sop_d[2] = sop_q[1];
      eop_d[2] = eop_q[1];
      // both squares are below 2^57, so the sum cannot carry out of PWR_WIDTH
      s3_pwr_d = s2_rr_q + s2_ii_q;
      idx_d[3] = idx_q[2];
      sop_d[3] = sop_q[2];
      eop_d[3] = eop_q[2];
    end

    fifo_wr_en   = vld_pipe_q[3] && fifo_wr_vld;
    fifo_wr_data = {sop_q[3], eop_q[3], idx_q[3], s3_pwr_q};
    if (fifo_wr_en && eop_q[3]) frame_cnt_d = frame_cnt_q + 16'd1;

    running   = (state_q == RUN);
    frame_cnt = frame_cnt_q;
    frame_err = frame_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      vld_pipe_q  <= '0;
      sop_q       <= '0;
      eop_q       <= '0;
      idx_q       <= '0;
      s1_re_q     <= '0;
      s1_im_q     <= '0;
      s2_rr_q     <= '0;
      s2_ii_q     <= '0;
      s3_pwr_q    <= '0;
      frame_cnt_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vld_pipe_q  <= vld_pipe_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      idx_q       <= idx_d;
      s1_re_q     <= s1_re_d;
      s1_im_q     <= s1_im_d;
      s2_rr_q     <= s2_rr_d;
      s2_ii_q     <= s2_ii_d;
      s3_pwr_q    <= s3_pwr_d;
      frame_cnt_q <= frame_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end
endmodule

// File: tb/tb_fft_modulus_calc.sv
// Self-checking bench for fft_modulus_calc: scoreboard of expected FIFO words plus directed corner sequences.
module tb_fft_modulus_calc;
  localparam int IW = 29, XW = 13, PW = 58, OW = 73, NB = 8192, NT = 8;

  logic          clk = 1'b0;
  logic          rst, en, in_valid, in_ready, in_last;
  logic          fifo_wr_en, fifo_wr_vld, running, frame_err;
  logic [IW-1:0] in_re, in_im;
  logic [OW-1:0] fifo_wr_data, held;
  logic [15:0]   frame_cnt;
  int            n_chk = 0, n_fail = 0, n_wr = 0, w0;
  logic [OW-1:0] exp_q[$];

  typedef struct {
    logic signed [IW-1:0] re;
    logic signed [IW-1:0] im;
    logic [PW-1:0]        pwr;
  } vec_t;
  vec_t tbl[NT];

  always #5 clk = ~clk;

  fft_modulus_calc dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_vld(fifo_wr_vld), .fifo_wr_data(fifo_wr_data), .running(running),
    .frame_cnt(frame_cnt), .frame_err(frame_err)
  );

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [OW-1:0] mk_word(input logic sop, input logic eop, input int idx,
                                            input logic [PW-1:0] p);
    logic [XW-1:0] ix;
    ix = XW'(idx);
    return {sop, eop, ix, p};
  endfunction

  function automatic logic [PW-1:0] model_pwr(input logic signed [IW-1:0] re,
                                              input logic signed [IW-1:0] im);
    longint r, i;
    r = longint'(re);
    i = longint'(im);
    return PW'(r * r + i * i);
  endfunction

  // Sample just before the next posedge: a high fifo_wr_en here is one FIFO write.
  always @(negedge clk) begin
    #2;
    if (!rst && fifo_wr_en) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got %h, required no write", fifo_wr_data);
      end else begin
        chk("wr_word", fifo_wr_data, exp_q.pop_front());
      end
    end
  end

  task automatic send_beat(input logic signed [IW-1:0] re, input logic signed [IW-1:0] im,
                           input logic last, input logic exp_wr, input logic [OW-1:0] word);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = im;
    in_last  = last;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_accept: in_ready 0 for 200 cycles, required 1");
    end else if (exp_wr) begin
      exp_q.push_back(word);
    end
    @(negedge clk);
  endtask

  // mode 0: re=3 im=-4; mode 1: random; mode 2: table vectors first, then random
  task automatic send_frame(input int n, input int mode, input logic exp_wr,
                            input logic last_end, input int en_off_at);
    logic signed [IW-1:0] re, im;
    logic [PW-1:0]        p;
    logic                 last, sop, eop;
    for (int i = 0; i < n; i++) begin
      if (i == en_off_at) en = 1'b0;
      if (mode == 0) begin
        re = IW'(3);
        im = IW'(-4);
      end else begin
        re = IW'($urandom);
        im = IW'($urandom);
      end
      p = model_pwr(re, im);
      if (mode == 2 && i < NT) begin
        re = tbl[i].re;
        im = tbl[i].im;
        p  = tbl[i].pwr;
      end
      last = last_end && (i == n - 1);
      sop  = (i % NB) == 0;
      eop  = last || ((i % NB) == NB - 1);
      send_beat(re, im, last, exp_wr, mk_word(sop, eop, i % NB, p));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d words still pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{IW'(-(1 << 28)),     IW'(-(1 << 28)), 58'h200000000000000};
    tbl[1] = '{IW'((1 << 28) - 1),  IW'(0),          58'h0FFFFFFE0000001};
    tbl[2] = '{IW'((1 << 28) - 1),  IW'(-(1 << 28)), 58'h1FFFFFFE0000001};
    tbl[3] = '{IW'(0),              IW'(0),          58'h0};
    tbl[4] = '{IW'(-1),             IW'(1),          58'h2};
    tbl[5] = '{IW'(3),              IW'(-4),         58'd25};
    tbl[6] = '{IW'(1000),           IW'(-1000),      58'd2000000};
    tbl[7] = '{IW'(-7),             IW'(0),          58'd49};

    rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0; in_last = 1'b0;
    fifo_wr_vld = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en",     OW'(fifo_wr_en), OW'(0));
    chk("rst_wr_data",   fifo_wr_data,    '0);
    chk("rst_running",   OW'(running),    OW'(0));
    chk("rst_frame_cnt", OW'(frame_cnt),  OW'(0));
    chk("rst_frame_err", OW'(frame_err),  OW'(0));
    chk("rst_in_ready",  OW'(in_ready),   OW'(1));
    rst = 1'b0;
    en  = 1'b1;

    // Alignment: partial frame discarded, then a full constant frame
    w0 = n_wr;
    send_frame(5, 0, 1'b0, 1'b1, -1);
    chk("align_running", OW'(running), OW'(1));
    chk("align_no_write", OW'(n_wr - w0), OW'(0));
    send_frame(NB, 0, 1'b1, 1'b1, -1);
    wait_drain();
    chk("f1_writes",    OW'(n_wr - w0), OW'(NB));
    chk("f1_frame_cnt", OW'(frame_cnt), OW'(1));
    chk("f1_frame_err", OW'(frame_err), OW'(0));

    // Table-driven extremes at the head of a full frame
    w0 = n_wr;
    send_frame(NB, 2, 1'b1, 1'b1, -1);
    wait_drain();
    chk("tbl_writes",    OW'(n_wr - w0), OW'(NB));
    chk("tbl_frame_cnt", OW'(frame_cnt), OW'(2));

    // Backpressure: 10 stalled cycles mid-frame
    w0 = n_wr;
    fork
      send_frame(NB, 1, 1'b1, 1'b1, -1);
      begin
        repeat (3000) @(negedge clk);
        fifo_wr_vld = 1'b0;
        #2;
        held = fifo_wr_data;
        for (int k = 0; k < 10; k++) begin
          chk("bp_in_ready", OW'(in_ready),   OW'(0));
          chk("bp_wr_en",    OW'(fifo_wr_en), OW'(0));
          if (k > 0) chk("bp_data_hold", fifo_wr_data, held);
          @(negedge clk);
          if (k < 9) #2;
        end
        fifo_wr_vld = 1'b1;
      end
    join
    wait_drain();
    chk("bp_writes",    OW'(n_wr - w0), OW'(NB));
    chk("bp_frame_cnt", OW'(frame_cnt), OW'(3));

    // Stop at boundary: en drops at bin 100, frame still completes
    w0 = n_wr;
    send_frame(NB, 1, 1'b1, 1'b1, 100);
    wait_drain();
    chk("stop_writes",    OW'(n_wr - w0), OW'(NB));
    chk("stop_running",   OW'(running),   OW'(0));
    chk("stop_frame_cnt", OW'(frame_cnt), OW'(4));
    w0 = n_wr;
    send_frame(20, 1, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);
    chk("idle_no_write", OW'(n_wr - w0), OW'(0));
    en = 1'b1;
    send_frame(7, 1, 1'b0, 1'b1, -1);
    repeat (6) @(negedge clk);
    chk("realign_running",  OW'(running),   OW'(1));
    chk("realign_no_write", OW'(n_wr - w0), OW'(0));

    // Missing in_last: bin 8191 forced to eop, error flagged
    chk("pre_err_frame_err", OW'(frame_err), OW'(0));
    send_frame(NB, 1, 1'b1, 1'b0, -1);
    wait_drain();
    chk("wrap_frame_err", OW'(frame_err), OW'(1));
    chk("wrap_frame_cnt", OW'(frame_cnt), OW'(5));

    // Reset while the output stage is stalled and full
    fifo_wr_vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_re    = IW'($urandom);
      in_im    = IW'($urandom);
      @(negedge clk);
    end
    #1;
    chk("stall_full_in_ready", OW'(in_ready), OW'(0));
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    fifo_wr_vld = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_stall_wr_en",     OW'(fifo_wr_en), OW'(0));
    chk("rst_stall_running",   OW'(running),    OW'(0));
    chk("rst_stall_frame_cnt", OW'(frame_cnt),  OW'(0));
    chk("rst_stall_frame_err", OW'(frame_err),  OW'(0));
    @(negedge clk);
    rst = 1'b0;

    // Early in_last at bin 50 after realigning
    w0 = n_wr;
    send_frame(3, 1, 1'b0, 1'b1, -1);
    chk("early_pre_frame_err", OW'(frame_err), OW'(0));
    send_frame(51, 1, 1'b1, 1'b1, -1);
    wait_drain();
    chk("early_writes",    OW'(n_wr - w0), OW'(51));
    chk("early_frame_err", OW'(frame_err), OW'(1));
    chk("early_frame_cnt", OW'(frame_cnt), OW'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
